// File: rtl/mult_booth_ctrl.sv
// mult_booth_ctrl: sequencing controller for a combinational signed radix-4
// Booth multiplier datapath. Accepts MUL/MULH requests, registers 16 Booth
// partial products, drives the datapath enable and holds the captured result
// until writeback accepts it. A == -2^31 is resolved locally (SPECIAL) because
// its -2A partial does not fit in LENGTH+1 bits.
// Optional feature macro: MULT_CTRL_ZERO_BYPASS_EN (zero operand -> result 0
// straight from accept, datapath untouched).
module mult_booth_ctrl #(
  parameter int unsigned LENGTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LENGTH-1:0] req_op_a,
  input  logic [LENGTH-1:0] req_op_b,
  input  logic              req_high,
  input  logic [4:0]        req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LENGTH-1:0] resp_data,
  output logic [4:0]        resp_tag,
  output logic [LENGTH:0]   partial1_booth,
  output logic [LENGTH:0]   partial2_booth,
  output logic [LENGTH:0]   partial3_booth,
  output logic [LENGTH:0]   partial4_booth,
  output logic [LENGTH:0]   partial5_booth,
  output logic [LENGTH:0]   partial6_booth,
  output logic [LENGTH:0]   partial7_booth,
  output logic [LENGTH:0]   partial8_booth,
  output logic [LENGTH:0]   partial9_booth,
  output logic [LENGTH:0]   partial10_booth,
  output logic [LENGTH:0]   partial11_booth,
  output logic [LENGTH:0]   partial12_booth,
  output logic [LENGTH:0]   partial13_booth,
  output logic [LENGTH:0]   partial14_booth,
  output logic [LENGTH:0]   partial15_booth,
  output logic [LENGTH:0]   partial16_booth,
  output logic              enable_mult,
  output logic              fuct3,
  input  logic [LENGTH-1:0] mult_o,
  input  logic              mult_finish
);

  localparam int unsigned PP_W   = LENGTH + 1;
  localparam int unsigned PROD_W = 2 * LENGTH;
  localparam int unsigned NUM_PP = 16;
  localparam logic [LENGTH-1:0] MIN_NEG = {1'b1, {(LENGTH-1){1'b0}}};

`ifdef MULT_CTRL_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENCODE  = 3'd1,
    EXEC    = 3'd2,
    SPECIAL = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LENGTH-1:0]   a_q, a_d;
  logic [LENGTH-1:0]   b_q, b_d;
  logic                high_q, high_d;
  logic [4:0]          tag_q, tag_d;
  logic [LENGTH-1:0]   resp_data_q, resp_data_d;
  logic [PP_W-1:0]     pp_q [NUM_PP];
  logic [PP_W-1:0]     pp_d [NUM_PP];
  logic [PP_W-1:0]     pp_enc [NUM_PP];
  logic [PP_W-1:0]     a_ext;
  logic [LENGTH:0]     b_ext;
  logic [PROD_W-1:0]   b_sext;
  logic [PROD_W-1:0]   special_p;
  logic                accept;

  // Radix-4 Booth digit to signed multiple of A, in LENGTH+1 bits.
  function automatic logic [PP_W-1:0] booth_pp(input logic [2:0] dig,
                                               input logic [PP_W-1:0] a_x);
    logic [PP_W-1:0] a2;
    a2 = {a_x[PP_W-2:0], 1'b0};
    case (dig)
      3'b001, 3'b010: booth_pp = a_x;
      3'b011:         booth_pp = a2;
      3'b100:         booth_pp = PP_W'(0) - a2;
      3'b101, 3'b110: booth_pp = PP_W'(0) - a_x;
      default:        booth_pp = '0;
    endcase
  endfunction

  assign req_ready   = (state_q == IDLE) && !kill && !rst;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (state_q == DONE);
  assign enable_mult = (state_q == EXEC);
  assign fuct3       = high_q;
  assign resp_data   = resp_data_q;
  assign resp_tag    = tag_q;

  assign partial1_booth  = pp_q[0];
  assign partial2_booth  = pp_q[1];
  assign partial3_booth  = pp_q[2];
  assign partial4_booth  = pp_q[3];
  assign partial5_booth  = pp_q[4];
  assign partial6_booth  = pp_q[5];
  assign partial7_booth  = pp_q[6];
  assign partial8_booth  = pp_q[7];
  assign partial9_booth  = pp_q[8];
  assign partial10_booth = pp_q[9];
  assign partial11_booth = pp_q[10];
  assign partial12_booth = pp_q[11];
  assign partial13_booth = pp_q[12];
  assign partial14_booth = pp_q[13];
  assign partial15_booth = pp_q[14];
  assign partial16_booth = pp_q[15];

  // Booth encoding of the latched operands; digit i looks at B[2i+1:2i-1].
  always_comb begin
    a_ext = {a_q[LENGTH-1], a_q};
    b_ext = {b_q, 1'b0};
    for (int i = 0; i < NUM_PP; i++) begin
      pp_enc[i] = booth_pp(b_ext[2*i +: 3], a_ext);
    end
  end

  // A == -2^31 product computed directly: 0 - (sext(B) << (LENGTH-1)).
  always_comb begin
    b_sext    = {{LENGTH{b_q[LENGTH-1]}}, b_q};
    special_p = PROD_W'(0) - (b_sext << (LENGTH - 1));
  end

  // Next-state and datapath register updates; kill overrides everything.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    high_d      = high_q;
    tag_d       = tag_q;
    resp_data_d = resp_data_q;
    pp_d        = pp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d    = req_op_a;
          b_d    = req_op_b;
          high_d = req_high;
          tag_d  = req_tag;
          state_d = (req_op_a == MIN_NEG) ? SPECIAL : ENCODE;
          if (ZERO_BYPASS && ((req_op_a == '0) || (req_op_b == '0))) begin
            state_d     = DONE;
            resp_data_d = '0;
          end
        end
      end
      ENCODE: begin
        pp_d    = pp_enc;
        state_d = EXEC;
      end
      EXEC: begin
        if (mult_finish) begin
          resp_data_d = mult_o;
          state_d     = DONE;
        end
      end
      SPECIAL: begin
        resp_data_d = high_q ? special_p[PROD_W-1:LENGTH] : special_p[LENGTH-1:0];
        state_d     = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      high_q      <= 1'b0;
      tag_q       <= '0;
      resp_data_q <= '0;
      for (int i = 0; i < NUM_PP; i++) begin
        pp_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      high_q      <= high_d;
      tag_q       <= tag_d;
      resp_data_q <= resp_data_d;
      pp_q        <= pp_d;
    end
  end

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Self-checking bench for mult_booth_ctrl with a behavioural datapath that
// sums the registered Booth partials; expectations come from a signed multiply.
module tb_mult_booth_ctrl;

  logic        clk = 1'b0;
  logic        rst, kill, req_valid, req_ready, req_high;
  logic [31:0] req_op_a, req_op_b;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic [32:0] pp [16];
  logic        enable_mult, fuct3, mult_finish;
  logic [31:0] mult_o;
  logic [63:0] acc;

  int checks   = 0;
  int failures = 0;
  int en_total = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          lat;
    int          en;
    int          en_start;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_booth_ctrl dut (
    .clk(clk), .rst(rst), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_high(req_high), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .partial1_booth(pp[0]),   .partial2_booth(pp[1]),
    .partial3_booth(pp[2]),   .partial4_booth(pp[3]),
    .partial5_booth(pp[4]),   .partial6_booth(pp[5]),
    .partial7_booth(pp[6]),   .partial8_booth(pp[7]),
    .partial9_booth(pp[8]),   .partial10_booth(pp[9]),
    .partial11_booth(pp[10]), .partial12_booth(pp[11]),
    .partial13_booth(pp[12]), .partial14_booth(pp[13]),
    .partial15_booth(pp[14]), .partial16_booth(pp[15]),
    .enable_mult(enable_mult), .fuct3(fuct3),
    .mult_o(mult_o), .mult_finish(mult_finish)
  );

  // Combinational datapath: weighted sum of sign-extended partials.
  always_comb begin
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + ({{31{pp[i][32]}}, pp[i]} << (2 * i));
    end
    mult_o      = fuct3 ? acc[63:32] : acc[31:0];
    mult_finish = enable_mult;
  end

  // Count datapath-enable cycles.
  always @(posedge clk) en_total <= en_total + (enable_mult ? 1 : 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_CTRL_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) return 0;
`endif
    return (a == 32'h8000_0000) ? 1 : 2;
  endfunction

  task automatic check_all_zero(input string tag);
    logic [32:0] any;
    any = '0;
    for (int i = 0; i < 16; i++) any = any | pp[i];
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_tag"}, resp_tag, 0);
    check({tag, "_partials"}, any, 0);
    check({tag, "_enable_mult"}, enable_mult, 0);
    check({tag, "_fuct3"}, fuct3, 0);
  endtask

  // Drive one request, push its expectation; returns at the negedge after accept.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic high, input logic [4:0] tag);
    exp_t e;
    logic signed [63:0] sa, sbv, p;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op_a = a; req_op_b = b; req_high = high; req_tag = tag;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("req_ready", req_ready, 1);
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    p   = sa * sbv;
    e.data     = high ? p[63:32] : p[31:0];
    e.tag      = tag;
    e.lat      = exp_lat(a, b);
    e.en       = (e.lat == 2) ? 1 : 0;
    e.en_start = en_total;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall.
  task automatic receive(input int hold);
    exp_t e;
    int n;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("resp_valid", resp_valid, 1);
    check("latency", n, e.lat);
    check("resp_data", resp_data, e.data);
    check("resp_tag", resp_tag, e.tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", resp_data, e.data);
      check("hold_valid", resp_valid, 1);
      check("hold_req_ready", req_ready, 0);
    end
    check("enable_cycles", en_total - e.en_start, e.en);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check("post_valid", resp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t drop;
    logic [31:0] ra, rb;
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op_a = '0; req_op_b = '0; req_high = 1'b0; req_tag = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_req_ready", req_ready, 1);

    send(32'd7, 32'd6, 1'b0, 5'd3);                  receive(0);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 5'd4);  receive(0);
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 5'd5);  receive(0);
    send(32'hFFFF_FFFD, 32'd5, 1'b0, 5'd6);          receive(0);
    send(32'hFFFF_FFFD, 32'd5, 1'b1, 5'd7);          receive(0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd8);  receive(0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd9);  receive(0);
    send(32'h8000_0000, 32'd2, 1'b1, 5'd10);         receive(0);
    send(32'd7, 32'd0, 1'b0, 5'd11);                 receive(0);
    send(32'd0, 32'd9, 1'b1, 5'd12);                 receive(0);
    send(32'h8000_0000, 32'd0, 1'b1, 5'd13);         receive(0);

    // Stall in DONE for 5 cycles.
    send(32'h1234_5678, 32'h0000_5678, 1'b0, 5'd14); receive(5);

    // Kill during EXEC: no response, ready again next cycle.
    send(32'h55, 32'h33, 1'b1, 5'd15);
    drop = sb.pop_front();
    @(negedge clk);
    check("kill_in_exec_enable", enable_mult, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill_resp_valid", resp_valid, 0);
    check("kill_req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check("kill_no_resp", resp_valid, 0);

    // Reset during ENCODE clears every output.
    send(32'h7FFF_FFFF, 32'd3, 1'b1, 5'd17);
    drop = sb.pop_front();
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;

    // Random traffic, including the -2^31 corner.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) ra = 32'h8000_0000;
      send(ra, rb, 1'(i % 2), 5'(i + 18));
      receive(i % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_booth_ctrl.md
# mult_booth_ctrl

Sequencing controller for the combinational signed radix-4 Booth multiplier datapath in the execute stage. It accepts MUL/MULH requests over a valid/ready handshake and latches the operands. It Booth-encodes the multiplier into 16 registered 33-bit partial products and drives the datapath enable. It captures the result, then holds it until the writeback side accepts it. It also handles the A = −2^31 corner, where the 33-bit −2A partial overflows, without using the datapath.

## Interface
- LENGTH, 32, operand/result width; partial-product width is LENGTH+1.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; **synchronous, active-high**.
- kill  input  1  pipeline flush; aborts any in-flight operation.
- req_valid  input  1  request valid.
- req_ready  output  1  controller can accept a request.
- req_op_a  input  LENGTH  multiplicand A, signed.
- req_op_b  input  LENGTH  multiplier B, signed.
- req_high  input  1  0 = MUL (low word), 1 = MULH (high word).
- req_tag  input  5  destination register, returned unchanged.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  LENGTH  result word.
- resp_tag  output  5  tag of the result.
- partial1_booth … partial16_booth  output  LENGTH+1 each  registered Booth partials to the datapath.
- enable_mult  output  1  datapath enable.
- fuct3  output  1  datapath high/low select; equals the latched req_high.
- mult_o  input  LENGTH  datapath result.
- mult_finish  input  1  datapath result valid.

## Operation
- States: IDLE, ENCODE, EXEC, SPECIAL, DONE.
- req_ready is 1 only in IDLE with kill = 0 and rst = 0.
- Accept occurs when req_valid && req_ready. On accept, latch A, B, high and tag.
- Next state after accept: A == 0x80000000 → SPECIAL; otherwise → ENCODE.
- ENCODE:
  - Digit i (i = 0..15) uses {B[2i+1], B[2i], B[2i−1]}, with B[−1] = 0.
  - Digit map: 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - A is sign-extended to 33 bits; 2A is that value shifted left by 1; negation is 33-bit two's complement.
  - partial(i+1)_booth registers the digit-i result; state → EXEC.
- EXEC:
  - enable_mult = 1, fuct3 = high.
  - When mult_finish = 1, resp_data ← mult_o and state → DONE; otherwise stay in EXEC.
- SPECIAL:
  - P = 0 − (sext64(B) << 31), computed in 64 bits.
  - resp_data ← high ? P[63:32] : P[31:0]; state → DONE.
- DONE:
  - resp_valid = 1.
  - resp_data and resp_tag stay stable until resp_ready = 1, then → IDLE.
- enable_mult = 0 in every state other than EXEC.
- kill = 1 in any state:
  - Next state is IDLE; resp_valid drops next cycle; no response is produced.
  - kill wins over an accept or resp_ready in the same cycle.
- Reset value of every output is 0: req_ready, resp_valid, resp_data, resp_tag, all partials, enable_mult, fuct3.
- State returns to IDLE on reset, including mid-operation.

## Timing
- Normal path: accept at edge E0; ENCODE during E0–E1; EXEC during E1–E2; resp_valid high after E2. Result latency is 2 cycles.
- SPECIAL path: resp_valid high after E1. Result latency is 1 cycle.
- The datapath is combinational; mult_finish is expected in the first EXEC cycle.
- No overlap: the next accept is possible one cycle after the resp handshake. Minimum request spacing is 4 cycles.
- resp_ready held low stalls the controller in DONE indefinitely, with outputs unchanged.

## Configuration
- MULT_CTRL_ZERO_BYPASS_EN defined:
  - On accept with A == 0 or B == 0, go directly to DONE with resp_data = 0. resp_valid is high after E0; the datapath is not enabled.
  - The zero check has priority over the SPECIAL check.
- MULT_CTRL_ZERO_BYPASS_EN undefined: zero operands take the normal path (0 or SPECIAL per the A check), with identical results and normal latency.

## Test plan
- MUL, A=7, B=6 → resp_data=0x0000002A, tag echoed; resp_valid exactly 2 cycles after accept; enable_mult high for 1 cycle.
- MULH, A=B=0x7FFFFFFF → 0x3FFFFFFF. MUL with the same operands → 0x00000001.
- A=0xFFFFFFFD (−3), B=5: MUL → 0xFFFFFFF1; MULH → 0xFFFFFFFF.
- A=B=0x80000000 → SPECIAL path: MULH 0x40000000, MUL 0x00000000; A=0x80000000, B=2 → MULH 0xFFFFFFFF. Latency 1; enable_mult never high.
- Hold resp_ready=0 for 5 cycles in DONE → data stable, req_ready=0. Then assert kill during EXEC of the next request → no resp_valid, req_ready=1 the next cycle.
- Assert rst during ENCODE → all outputs 0 next cycle. With MULT_CTRL_ZERO_BYPASS_EN, B=0 → resp 0 after 0 cycles.
